// File: rtl/sigmoid_backward_021.sv
// Sigmoid backward pass dx = dy*y*(1-y), 3-stage elastic pipeline in Q(DATA_W-FRAC_W).FRAC_W.
// Define SIGMOID_BWD_ROUND_EN for round-half-up in the final shift; otherwise the shift truncates.
module sigmoid_backward_021 #(
    parameter int DATA_W = 32,
    parameter int FRAC_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              valid_in,
    output logic              ready_in,
    input  logic [DATA_W-1:0] y_in,
    input  logic [DATA_W-1:0] grad_in,
    output logic              valid_out,
    input  logic              ready_out,
    output logic [DATA_W-1:0] grad_out,
    output logic [15:0]       beat_count
);
    localparam int PW = DATA_W + FRAC_W + 2;
    localparam logic signed [DATA_W-1:0] ONE_W   = DATA_W'(1 << FRAC_W);
    localparam logic        [FRAC_W:0]   ONE_S   = (FRAC_W+1)'(1 << FRAC_W);

    logic              v1_q, v2_q, v3_q;
    logic [FRAC_W:0]   yc_q, yc_d;
    logic [FRAC_W:0]   s_q, s_d;
    logic [DATA_W-1:0] dy1_q, dy2_q;
    logic [DATA_W-1:0] grad_q, grad_d;
    logic [15:0]       cnt_q;
    logic              en;

    logic [2*FRAC_W+1:0] prod2;
    logic signed [PW-1:0] dy_ext, s_ext, p, p_r;

    assign en        = !v3_q || ready_out;
    assign ready_in  = en && !rst;
    assign valid_out = v3_q;
    assign grad_out  = grad_q;
    assign beat_count = cnt_q;

    // Stage 1: clamp y into [0, 1.0]
    always_comb begin
        yc_d = y_in[FRAC_W:0];
        if (y_in[DATA_W-1])
            yc_d = '0;
        else if ($signed(y_in) > ONE_W)
            yc_d = ONE_S;
    end

    // Stage 2: s = y*(1-y), truncated; never exceeds 0x4000
    always_comb begin
        prod2 = {{(FRAC_W+1){1'b0}}, yc_q} * {{(FRAC_W+1){1'b0}}, ONE_S - yc_q};
        s_d   = (FRAC_W+1)'(prod2 >> FRAC_W);
    end

    // Stage 3: signed dy * s, then scale back down by FRAC_W
    always_comb begin
        dy_ext = PW'($signed(dy2_q));
        s_ext  = PW'({1'b0, s_q});
        p      = dy_ext * s_ext;
`ifdef SIGMOID_BWD_ROUND_EN
        p_r    = p + PW'(1 << (FRAC_W-1));
`else
        p_r    = p;
`endif
        grad_d = DATA_W'(p_r >>> FRAC_W);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            v1_q   <= 1'b0;
            v2_q   <= 1'b0;
            v3_q   <= 1'b0;
            yc_q   <= '0;
            s_q    <= '0;
            dy1_q  <= '0;
            dy2_q  <= '0;
            grad_q <= '0;
            cnt_q  <= '0;
        end else begin
            if (en) begin
                v1_q <= valid_in;
                v2_q <= v1_q;
                v3_q <= v2_q;
                if (valid_in) begin
                    yc_q  <= yc_d;
                    dy1_q <= grad_in;
                end
                if (v1_q) begin
                    s_q   <= s_d;
                    dy2_q <= dy1_q;
                end
                if (v2_q)
                    grad_q <= grad_d;
            end
            if (v3_q && ready_out)
                cnt_q <= cnt_q + 16'd1;
        end
    end
endmodule

// File: doc/sigmoid_backward_021.md
SIGMOID_BACKWARD_021 -- requirements
Module: sigmoid_backward_021

Interface
REQ-001 Parameter: DATA_W, 32, width of gradient and activation words (signed fixed point).
REQ-002 Parameter: FRAC_W, 16, fractional bits, so the format is Q(DATA_W-FRAC_W).FRAC_W; 1.0 = 0x00010000.
REQ-003 Port: clk  input  1  single clock; all logic on rising edge.
REQ-004 Port: rst  input  1  synchronous, active-high reset.
REQ-005 Port: valid_in  input  1  input beat valid.
REQ-006 Port: ready_in  output  1  block accepts the input beat this cycle.
REQ-007 Port: y_in  input  DATA_W  forward sigmoid output y (signed).
REQ-008 Port: grad_in  input  DATA_W  upstream gradient dy (signed).
REQ-009 Port: valid_out  output  1  output beat valid.
REQ-010 Port: ready_out  input  1  downstream accepts the output beat.
REQ-011 Port: grad_out  output  DATA_W  dx = dy*y*(1-y) (signed).
REQ-012 Port: beat_count  output  16  number of output beats transferred; wraps 0xFFFF->0x0000.

Function
REQ-013 The block SHALL implement the backward pass of Sigmoid as a 3-stage pipeline, each stage holding a valid bit plus data.
REQ-014 Stage 1 SHALL clamp y: y<0 -> 0; y>0x00010000 -> 0x00010000; otherwise unchanged; it SHALL register the clamped y and dy.
REQ-015 Stage 2 SHALL compute s = (y_c*(0x10000-y_c))>>FRAC_W as an unsigned product truncated to 17 bits (max 0x4000), and register it with dy.
REQ-016 Stage 3 SHALL compute p = dy*s as a signed product of at least 49 bits, arithmetic-shift it right by FRAC_W, take the low DATA_W bits, and register the result on grad_out; no overflow is possible since |s|<=0.25.
REQ-017 Pipeline advance SHALL be en = !valid_out || ready_out; all stages move together only when en=1.
REQ-018 ready_in SHALL equal en (combinational); an input transfer occurs when valid_in && ready_in.
REQ-019 Latency SHALL be exactly 3 cycles from the input transfer to valid_out high when ready_out is held at 1; throughput SHALL be 1 beat per cycle.
REQ-020 While valid_out=1 && ready_out=0, grad_out and valid_out SHALL hold stable and no input SHALL be accepted.
REQ-021 Bubbles SHALL propagate as invalid stages; there is no bubble collapsing.
REQ-022 beat_count SHALL increment by 1 on each cycle with valid_out && ready_out, wrapping modulo 2^16.
REQ-023 Beat order SHALL be preserved; no beat may be dropped or duplicated.

Reset
REQ-024 When rst=1 at a clock edge, all stage valid bits SHALL clear, valid_out=0, grad_out=0 and beat_count=0.
REQ-025 A reset mid-operation SHALL discard all in-flight beats; ready_in SHALL be 1 in the cycle after reset deasserts.
REQ-026 During reset, ready_in SHALL read 0 and no input transfer SHALL occur.

Configuration
REQ-027 Macro SIGMOID_BWD_ROUND_EN SHALL control rounding in stage 3.
REQ-028 With SIGMOID_BWD_ROUND_EN defined, stage 3 SHALL add 2^(FRAC_W-1) to p before the arithmetic shift (round half up).
REQ-029 With SIGMOID_BWD_ROUND_EN undefined, stage 3 SHALL use a plain arithmetic shift (truncate toward minus infinity).
REQ-030 Stage 2 SHALL always truncate, in both builds.

Verification
REQ-031 y=0x00008000, dy=0x00010000, ready_out=1 -> grad_out=0x00004000 with valid_out high exactly 3 cycles after the transfer.
REQ-032 y=0x00008000, dy=0xFFFF0000 -> grad_out=0xFFFFC000; y=0xFFFF8000 or y=0x00020000 with dy=0x00010000 -> grad_out=0x00000000 (clamp).
REQ-033 y=0x00008000, dy=0x00000003 -> grad_out=0x00000000 without SIGMOID_BWD_ROUND_EN, and 0x00000001 with it.
REQ-034 Stream 8 back-to-back beats with ready_out low for cycles 4-6 -> outputs held stable, ready_in=0 while stalled, all 8 results in order, beat_count=8.
REQ-035 Assert rst with 2 beats in flight -> valid_out=0 and beat_count=0 next cycle; a fresh beat after reset emerges after 3 cycles.
REQ-036 Drive 65537 transfers -> beat_count wraps to 0x0001.
